mem_wb_pipe: RTL
================

Name: mem_wb_pipe

Overview:
- Parametrised MEM->WB pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, and an optional HI/LO write channel.
- Sits between the memory-access stage and the register-file/HI-LO write-back.
- Lets WB back-pressure MEM (e.g. a regfile port conflict) without a combinational ready path back through the pipe.
- Bubbles never produce architectural writes.

Parameters:
- DATA_W, 32, width of write-back data, HI and LO.
- REGADDR_W, 5, width of destination register address.
- HILO_EN, 1, 1 = HI/LO channel present; 0 = its outputs tied to 0 and its state removed.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries (exception/ERET).
- in_valid  in  1  MEM presents a valid instruction result.
- in_ready  out  1  pipe can accept this cycle; registered output.
- in_wd  in  REGADDR_W  destination register.
- in_wreg  in  1  register write enable.
- in_wdata  in  DATA_W  register write data.
- in_whilo  in  1  HI/LO write enable.
- in_hi  in  DATA_W  HI data.
- in_lo  in  DATA_W  LO data.
- out_valid  out  1  WB holds a valid entry.
- out_ready  in  1  WB consumes the entry this cycle.
- out_wd  out  REGADDR_W  head entry destination.
- out_wreg  out  1  head write enable, gated by out_valid.
- out_wdata  out  DATA_W  head write data.
- out_whilo  out  1  head HI/LO enable, gated by out_valid.
- out_hi  out  DATA_W  head HI data.
- out_lo  out  DATA_W  head LO data.

Behaviour:
- Storage: a main register (head, drives the out_* ports) and a skid register; each entry holds {wd, wreg, wdata, whilo, hi, lo}.
- States, encoded from valid bits: EMPTY (0 entries), ONE (main only), TWO (main + skid).
- Handshakes: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (state != TWO), registered. It depends on no same-cycle input.
- out_valid = (state != EMPTY).
- out_wreg = main.wreg & out_valid; out_whilo = main.whilo & out_valid & HILO_EN.
- Transitions, evaluated on posedge clk:
  - EMPTY: accept -> ONE, main <= input.
  - ONE: accept & pop -> ONE, main <= input. accept & !pop -> TWO, skid <= input. pop & !accept -> EMPTY. Neither -> ONE, hold.
  - TWO: pop -> ONE, main <= skid (in_ready is 0, so no accept). !pop -> TWO, hold.
- Latency: 1 cycle from accept to out_valid when the pipe is EMPTY or popping. Throughput is 1 entry/cycle while out_ready is held high.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- flush:
  - Next state is EMPTY and every held entry is discarded.
  - An input accepted in the same cycle is also discarded.
  - A pop in the same cycle still completes; the WB consumer samples the head before the edge.
  - in_ready is 1 on the following cycle.
- Priority: rst > flush > accept/pop.
- Reset / flush output values:
  - out_valid=0, out_wd=0 (NOP register address), out_wreg=0, out_wdata=0, out_whilo=0, out_hi=0, out_lo=0, in_ready=1.
  - A flush also zeros the main data fields, so a bubble presents the same values as after reset.
- Reset mid-transfer drops all entries, regardless of in_valid or out_ready.
- Bubble presentation: out_wreg and out_whilo are never 1 while out_valid=0.
- Data fields are unmodified copies: no width conversion or sign extension.

Decomposition:
- Shared package/macro file holds:
  - Encodings RSTENABLE, WRITEENABLE/WRITEDISABLE, NOPREGADDR, ZEROWORD.
  - The 2-bit state encoding (EMPTY/ONE/TWO).
  - A packed wb_entry struct/field-offset macros, sized from DATA_W and REGADDR_W.
- One natural sub-module: wb_entry_reg, a single enable-loaded entry register with clear. It is instantiated twice (main, skid).
- Control FSM stays in mem_wb_pipe.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_wd=5 -> out_valid=0, out_wd=0, out_wreg=0, out_wdata=0, in_ready=1 throughout.
- Streaming: out_ready=1; send wd=1..4 with wdata 0xA1..0xA4 back-to-back -> each appears 1 cycle after accept, in order; in_ready stays 1.
- Back-pressure:
  - Stimulus: out_ready=0; send wd=7 (0x77), wd=8 (0x88), wd=9 (0x99, offered).
  - in_ready drops to 0 after the second accept; the third is not accepted.
  - Raising out_ready yields 0x77, then 0x88, then 0x99, with no loss or duplication.
- Flush in TWO with same-cycle offer: flush=1, in_valid=1 -> next cycle out_valid=0, out_wreg=0, in_ready=1; the offered entry never appears.
- HI/LO: in_whilo=1, hi=0xDEAD0000, lo=0x0000BEEF, in_wreg=0 -> out_whilo=1 with those values and out_wreg=0. With HILO_EN=0, out_whilo/out_hi/out_lo stay 0.
- Bubble gating: leave main loaded with wreg=1, then pop with no new input -> out_valid=0 and out_wreg=0 the next cycle.

Source files
------------

// File: rtl/mem_wb_pipe_pkg.sv
// Shared encodings, control-state encoding and entry sizing for the MEM->WB pipe.
package mem_wb_pipe_pkg;

  localparam logic        RSTENABLE    = 1'b1;
  localparam logic        WRITEENABLE  = 1'b1;
  localparam logic        WRITEDISABLE = 1'b0;
  localparam int unsigned NOPREGADDR   = 0;
  localparam int unsigned ZEROWORD     = 0;

  // Encoded as {skid_valid, main_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_e;

  // Width of one {wd, wreg, wdata, whilo, hi, lo} entry
  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned regaddr_w);
    return 3 * data_w + regaddr_w + 2;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_wb_entry_reg.sv
// One write-back entry register: synchronous clear wins over enable-load.
module wb_entry_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush and optional HI/LO channel.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REGADDR_W = 5,
  parameter int unsigned HILO_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REGADDR_W-1:0] in_wd,
  input  logic                 in_wreg,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic                 in_whilo,
  input  logic [DATA_W-1:0]    in_hi,
  input  logic [DATA_W-1:0]    in_lo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REGADDR_W-1:0] out_wd,
  output logic                 out_wreg,
  output logic [DATA_W-1:0]    out_wdata,
  output logic                 out_whilo,
  output logic [DATA_W-1:0]    out_hi,
  output logic [DATA_W-1:0]    out_lo
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W, REGADDR_W);

  typedef struct packed {
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [DATA_W-1:0]    wdata;
    logic                 whilo;
    logic [DATA_W-1:0]    hi;
    logic [DATA_W-1:0]    lo;
  } wb_entry_t;

  state_e    state_q, state_d;
  wb_entry_t in_e, main_d, main_q, skid_q;
  logic      accept, pop;
  logic      main_ld, main_from_skid, skid_ld, clr_c, entry_clr;

  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign entry_clr = (rst == RSTENABLE) | clr_c;

  // Pack the incoming result; HI/LO fields stay constant zero when the channel is absent
  always_comb begin
    in_e       = '0;
    in_e.wd    = in_wd;
    in_e.wreg  = in_wreg;
    in_e.wdata = in_wdata;
    if (HILO_EN != 0) begin
      in_e.whilo = in_whilo;
      in_e.hi    = in_hi;
      in_e.lo    = in_lo;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_e;

  wb_entry_reg #(.W(ENTRY_W)) u_main (
    .clk (clk),
    .clr (entry_clr),
    .en  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  wb_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk (clk),
    .clr (entry_clr),
    .en  (skid_ld),
    .d   (in_e),
    .q   (skid_q)
  );

  // State register; handshake flags are flopped from the next state
  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state_q   <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d != ST_TWO);
      out_valid <= (state_d != ST_EMPTY);
    end
  end

  // Next state and entry-register controls; flush overrides any accept/pop
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    clr_c          = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_ld = 1'b1;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d        = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          clr_c   = 1'b1;
        end
      endcase
    end
  end

  // Head presentation; enables are masked so a bubble never writes
  always_comb begin
    out_wd    = main_q.wd;
    out_wreg  = (main_q.wreg == WRITEENABLE) & out_valid;
    out_wdata = main_q.wdata;
    out_whilo = WRITEDISABLE;
    out_hi    = DATA_W'(ZEROWORD);
    out_lo    = DATA_W'(ZEROWORD);
    if (HILO_EN != 0) begin
      out_whilo = (main_q.whilo == WRITEENABLE) & out_valid;
      out_hi    = main_q.hi;
      out_lo    = main_q.lo;
    end
  end

endmodule
